// File: rtl/riscv_pkg.sv
// Types shared by the decode/execute boundary: special-instruction codes and
// the decoded bundle handed from ID to EX.
package riscv_pkg;

  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    JAL   = 3'd1,
    JALR  = 3'd2,
    AUIPC = 3'd3,
    LUI   = 3'd4
  } specinst_e;

  typedef struct packed {
    logic            ers1;
    logic            ers2;
    specinst_e       specinst;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imme;
  } id_ex_bundle_t;

endpackage

// File: rtl/id_ex_entry.sv
// One pipeline slot: a valid bit plus a decoded bundle.
// Clear drops only the valid bit, so the bundle lingers as last-seen payload.
module id_ex_entry
  import riscv_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load,
  input  logic          clear,
  input  id_ex_bundle_t d,
  output logic          valid,
  output id_ex_bundle_t q
);

  // NOTE: sequential state is written with <= only, so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid <= 1'b0;
      // NOTE: the payload is reset as well because downstream observes it
      // even when invalid, and it must read as zero right after reset.
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with a two-entry skid buffer, flush and a
// saturating backpressure counter. Main entry drives out_*; skid never bypassed.
module id_ex_pipe
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  in_ers1_i,
  input  logic                  in_ers2_i,
  input  logic [2:0]            in_specinst_i,
  input  logic [DATA_WIDTH-1:0] in_rs1_i,
  input  logic [DATA_WIDTH-1:0] in_rs2_i,
  input  logic [DATA_WIDTH-1:0] in_pc_i,
  input  logic [DATA_WIDTH-1:0] in_imme_i,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_ers1_o,
  output logic                  out_ers2_o,
  output logic [2:0]            out_specinst_o,
  output logic [DATA_WIDTH-1:0] out_rs1_o,
  output logic [DATA_WIDTH-1:0] out_rs2_o,
  output logic [DATA_WIDTH-1:0] out_pc_o,
  output logic [DATA_WIDTH-1:0] out_imme_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

  if (DATA_WIDTH != XLEN) begin : g_width_check
    $error("id_ex_pipe: DATA_WIDTH must equal riscv_pkg::XLEN");
  end

  id_ex_bundle_t in_bundle, main_d, main_q, skid_q;
  logic main_valid, skid_valid;
  logic accept, drain;
  logic main_load, main_clear, skid_load, skid_clear;

  always_comb begin
    in_bundle.ers1     = in_ers1_i;
    in_bundle.ers2     = in_ers2_i;
    in_bundle.specinst = specinst_e'(in_specinst_i);
    in_bundle.rs1      = in_rs1_i;
    in_bundle.rs2      = in_rs2_i;
    in_bundle.pc       = in_pc_i;
    in_bundle.imme     = in_imme_i;
  end

  // Ready depends only on the skid flop (and reset), never on out_ready_i.
  assign in_ready_o = ~skid_valid & ~rst_i;
  assign accept     = in_valid_i & in_ready_o;
  assign drain      = main_valid & out_ready_i;

  // NOTE: every control is a plain continuous assignment or fully assigned in
  // always_comb, so no path can leave a signal unassigned and infer a latch.
  always_comb begin
    main_d     = skid_valid ? skid_q : in_bundle;
    main_load  = ~flush_i & ((accept & (~main_valid | drain)) | (drain & skid_valid));
    main_clear = flush_i | (drain & ~skid_valid & ~accept);
    skid_load  = ~flush_i & accept & main_valid & ~drain;
    skid_clear = flush_i | (drain & skid_valid);
  end

  id_ex_entry u_main (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  id_ex_entry u_skid (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_bundle),
    .valid (skid_valid),
    .q     (skid_q)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (main_valid & ~out_ready_i & ~flush_i & ~(&stall_cnt_o)) begin
      stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
    end
  end

  assign out_valid_o    = main_valid;
  assign out_ers1_o     = main_q.ers1;
  assign out_ers2_o     = main_q.ers2;
  assign out_specinst_o = main_q.specinst;
  assign out_rs1_o      = main_q.rs1;
  assign out_rs2_o      = main_q.rs2;
  assign out_pc_o       = main_q.pc;
  assign out_imme_o     = main_q.imme;

  // The skid entry is only ever filled behind a valid main entry.
  a_no_orphan_skid : assert property (@(posedge clk_i) disable iff (rst_i)
    !(skid_valid && !main_valid));

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed plus randomized bench for id_ex_pipe against a queue-based model;
// a 4-bit-counter instance shares the stimulus to exercise saturation.
module tb_id_ex_pipe;
  import riscv_pkg::*;

  localparam int DW = 64;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic          in_ers1, in_ers2, out_ers1, out_ers2;
  logic [2:0]    in_specinst, out_specinst;
  logic [DW-1:0] in_rs1, in_rs2, in_pc, in_imme;
  logic [DW-1:0] out_rs1, out_rs2, out_pc, out_imme;
  logic [CW-1:0] stall_cnt;

  logic          d4_in_ready, d4_out_valid, d4_ers1, d4_ers2;
  logic [2:0]    d4_specinst;
  logic [DW-1:0] d4_rs1, d4_rs2, d4_pc, d4_imme;
  logic [3:0]    d4_stall_cnt;

  id_ex_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_ers1_i(in_ers1), .in_ers2_i(in_ers2), .in_specinst_i(in_specinst),
    .in_rs1_i(in_rs1), .in_rs2_i(in_rs2), .in_pc_i(in_pc), .in_imme_i(in_imme),
    .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_ers1_o(out_ers1), .out_ers2_o(out_ers2), .out_specinst_o(out_specinst),
    .out_rs1_o(out_rs1), .out_rs2_o(out_rs2), .out_pc_o(out_pc),
    .out_imme_o(out_imme), .stall_cnt_o(stall_cnt)
  );

  id_ex_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(d4_in_ready),
    .in_ers1_i(in_ers1), .in_ers2_i(in_ers2), .in_specinst_i(in_specinst),
    .in_rs1_i(in_rs1), .in_rs2_i(in_rs2), .in_pc_i(in_pc), .in_imme_i(in_imme),
    .flush_i(flush), .out_valid_o(d4_out_valid), .out_ready_i(out_ready),
    .out_ers1_o(d4_ers1), .out_ers2_o(d4_ers2), .out_specinst_o(d4_specinst),
    .out_rs1_o(d4_rs1), .out_rs2_o(d4_rs2), .out_pc_o(d4_pc),
    .out_imme_o(d4_imme), .stall_cnt_o(d4_stall_cnt)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 1'b0;

  // Reference model: in-flight bundles in acceptance order, the payload last
  // shown at the output, and an unbounded stall count.
  id_ex_bundle_t   mq[$];
  id_ex_bundle_t   last_out = '0;
  longint unsigned m_cnt    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic id_ex_bundle_t mk(input logic [63:0] pc, input logic [63:0] imme,
                                       input specinst_e si);
    id_ex_bundle_t b;
    b.ers1     = 1'($urandom);
    b.ers2     = 1'($urandom);
    b.specinst = si;
    b.rs1      = {$urandom, $urandom};
    b.rs2      = {$urandom, $urandom};
    b.pc       = pc;
    b.imme     = imme;
    return b;
  endfunction

  function automatic id_ex_bundle_t rand_b();
    return mk({$urandom, $urandom}, {$urandom, $urandom},
              specinst_e'($urandom_range(0, 4)));
  endfunction

  task automatic compare_all();
    logic [63:0] sat4;
    sat4 = (m_cnt > 64'd15) ? 64'd15 : m_cnt;
    check("out_valid",    out_valid,    mq.size() > 0);
    check("in_ready",     in_ready,     (mq.size() < 2) && !rst);
    check("out_ers1",     out_ers1,     last_out.ers1);
    check("out_ers2",     out_ers2,     last_out.ers2);
    check("out_specinst", out_specinst, last_out.specinst);
    check("out_rs1",      out_rs1,      last_out.rs1);
    check("out_rs2",      out_rs2,      last_out.rs2);
    check("out_pc",       out_pc,       last_out.pc);
    check("out_imme",     out_imme,     last_out.imme);
    check("stall_cnt",    stall_cnt,    m_cnt[31:0]);
    check("stall_cnt4",   d4_stall_cnt, sat4);
    check("out_valid4",   d4_out_valid, mq.size() > 0);
    check("out_pc4",      d4_pc,        last_out.pc);
  endtask

  task automatic model_step(input id_ex_bundle_t b);
    bit acc, dr;
    if (rst) begin
      mq.delete();
      last_out = '0;
      m_cnt    = 0;
    end else begin
      acc = in_valid && (mq.size() < 2);
      dr  = (mq.size() > 0) && out_ready;
      if ((mq.size() > 0) && !out_ready && !flush && (m_cnt < 64'hFFFF_FFFF)) m_cnt++;
      if (flush) begin
        mq.delete();
      end else begin
        if (dr)  void'(mq.pop_front());
        if (acc) mq.push_back(b);
      end
      if (mq.size() > 0) last_out = mq[0];
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check registered outputs
  // from the previous rising edge, then advance the model across the next one.
  task automatic cycle(input bit v, input bit r, input bit f, input bit rs,
                       input id_ex_bundle_t b);
    @(negedge clk);
    in_valid    = v;
    out_ready   = r;
    flush       = f;
    rst         = rs;
    in_ers1     = b.ers1;
    in_ers2     = b.ers2;
    in_specinst = b.specinst;
    in_rs1      = b.rs1;
    in_rs2      = b.rs2;
    in_pc       = b.pc;
    in_imme     = b.imme;
    #1;
    if (checking) compare_all();
    model_step(b);
    checking = 1'b1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_ers1 = 1'b0; in_ers2 = 1'b0; in_specinst = '0;
    in_rs1 = '0; in_rs2 = '0; in_pc = '0; in_imme = '0;

    cycle(0, 1, 0, 1, rand_b());
    cycle(0, 1, 0, 1, rand_b());

    // Single JAL bundle: visible one cycle, gone the next.
    cycle(1, 1, 0, 0, mk(64'h1000, 64'h10, JAL));
    cycle(0, 1, 0, 0, rand_b());
    cycle(0, 1, 0, 0, rand_b());

    // Back-to-back stream at full rate.
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, mk(64'(4 * i), 64'(i), NONE));
    cycle(0, 1, 0, 0, rand_b());
    cycle(0, 1, 0, 0, rand_b());

    // Backpressure into FULL2, offered-but-refused bundles, then release.
    cycle(1, 0, 0, 0, mk(64'h100, 64'h1, AUIPC));
    cycle(1, 0, 0, 0, mk(64'h104, 64'h2, LUI));
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, mk(64'h108, 64'h3, JALR));
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, rand_b());

    // Flush in FULL2 and in FULL1 with a bundle offered at the same time.
    cycle(1, 0, 0, 0, mk(64'h300, 64'h0, NONE));
    cycle(1, 0, 0, 0, mk(64'h304, 64'h0, NONE));
    cycle(1, 0, 1, 0, mk(64'h200, 64'h0, JAL));
    cycle(0, 1, 0, 0, rand_b());
    cycle(1, 0, 0, 0, mk(64'h310, 64'h0, NONE));
    cycle(1, 1, 1, 0, mk(64'h200, 64'h0, JAL));
    cycle(0, 1, 0, 0, rand_b());
    cycle(0, 1, 0, 0, rand_b());

    // Reset while in FULL2 with five stall cycles counted.
    cycle(0, 1, 0, 1, rand_b());
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, rand_b());
    cycle(1, 0, 0, 1, rand_b());
    cycle(0, 1, 0, 0, rand_b());
    cycle(0, 1, 0, 0, rand_b());

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++)
      cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 32) == 0,
            ($urandom % 128) == 0, rand_b());

    // Long backpressure so the 4-bit counter saturates and holds.
    cycle(0, 1, 0, 1, rand_b());
    for (int i = 0; i < 25; i++) cycle(1, 0, 0, 0, rand_b());
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, rand_b());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
